// File: rtl/reg_alu_sequencer.sv
// Purpose  : multi-cycle LDI/ADD/SUB/MUL controller feeding a 4x16 register file through
//            one read port and one write port.
// Latency  : accept-to-writeback LDI 1, ADD/SUB 4, MUL 3+WIDTH cycles.
// Backpres.: instr_ready only in IDLE and not in reset; one instruction in flight, no overlap.
//
// Ports:
//   clk, reset                        clock and synchronous active-high reset
//   instr_valid/instr_ready           instruction handshake (accept when both high)
//   instr_op/dst/src/imm              opcode (00 LDI,01 ADD,10 SUB,11 MUL), dst (= operand A),
//                                     src (operand B), immediate for LDI
//   rf_read_index / rf_read_data      register file read port (combinational read data)
//   rf_write_index/_enable/_data      register file write port, driven for one WB cycle
//   busy, done                        not-IDLE indicator; one-cycle pulse with the write
//   flag_zero, flag_carry             present only when ALU_FLAGS_EN is defined; updated
//                                     on the writeback edge
module reg_alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       instr_op,
  input  logic [IDX_W-1:0] instr_dst,
  input  logic [IDX_W-1:0] instr_src,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [IDX_W-1:0] rf_read_index,
  input  logic [WIDTH-1:0] rf_read_data,
  output logic [IDX_W-1:0] rf_write_index,
  output logic             rf_write_enable,
  output logic [WIDTH-1:0] rf_write_data,
  output logic             busy,
  output logic             done
`ifdef ALU_FLAGS_EN
  ,
  output logic             flag_zero,
  output logic             flag_carry
`endif
);

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam int CNT_W = 5;

  // The multiplier only needs the full double-width product when the carry
  // flag has to report overflow; otherwise the low WIDTH bits suffice.
`ifdef ALU_FLAGS_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [IDX_W-1:0] dst_q;
  logic [IDX_W-1:0] src_q;
  logic [IDX_W-1:0] read_idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // operand B; shifted right one bit per MUL step
  logic [PW-1:0]    mcand_q;   // operand A, shifted left one bit per MUL step
  logic [PW-1:0]    acc_q;     // shift-add partial product
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             mul_last;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] diff_w;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    acc_next;

`ifdef ALU_FLAGS_EN
  logic             carry_q;
  logic             sum_c;
  logic             diff_c;
`endif

  // Instruction fields are only looked at on the accept edge, so garbage on
  // instr_* while instr_valid is low never reaches any state.
  assign accept   = instr_valid && (state_q == IDLE) && !reset;
  assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_FLAGS_EN
  // The extra top bit of the subtraction is the borrow, i.e. A < B.
  assign {sum_c, sum_w}   = {1'b0, a_q} + {1'b0, b_q};
  assign {diff_c, diff_w} = {1'b0, a_q} - {1'b0, b_q};
`else
  assign sum_w  = a_q + b_q;
  assign diff_w = a_q - b_q;
`endif

  assign partial  = b_q[0] ? mcand_q : '0;
  assign acc_next = acc_q + partial;

  assign rf_read_index  = read_idx_q;
  assign rf_write_index = dst_q;
  assign rf_write_data  = result_q;

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next state and control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    instr_ready     = (state_q == IDLE) && !reset;
    busy            = (state_q != IDLE);
    // Gating with reset makes an abort in the WB cycle suppress the write.
    rf_write_enable = (state_q == WB) && !reset;
    done            = (state_q == WB) && !reset;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (instr_op == OP_LDI) ? WB : RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: state_d = EXEC;
      EXEC: begin
        if (op_q != OP_MUL || mul_last) begin
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_LDI;
      dst_q      <= '0;
      src_q      <= '0;
      read_idx_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
`ifdef ALU_FLAGS_EN
      carry_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= instr_op;
            dst_q <= instr_dst;
            src_q <= instr_src;
            if (instr_op == OP_LDI) begin
              result_q <= instr_imm;
`ifdef ALU_FLAGS_EN
              carry_q  <= 1'b0;
`endif
            end else begin
              // Presented during RD_A; LDI leaves the read index untouched.
              read_idx_q <= instr_dst;
            end
          end
        end

        RD_A: begin
          a_q        <= rf_read_data;
          read_idx_q <= src_q;
        end

        RD_B: begin
          b_q     <= rf_read_data;
          mcand_q <= PW'(a_q);
          acc_q   <= '0;
          cnt_q   <= '0;
        end

        EXEC: begin
          case (op_q)
            OP_ADD: begin
              result_q <= sum_w;
`ifdef ALU_FLAGS_EN
              carry_q  <= sum_c;
`endif
            end
            OP_SUB: begin
              result_q <= diff_w;
`ifdef ALU_FLAGS_EN
              carry_q  <= diff_c;
`endif
            end
            OP_MUL: begin
              // One bit of B per cycle, LSB first.
              acc_q   <= acc_next;
              mcand_q <= mcand_q << 1;
              b_q     <= b_q >> 1;
              cnt_q   <= cnt_q + CNT_W'(1);
              if (mul_last) begin
                result_q <= acc_next[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
                carry_q  <= |acc_next[PW-1:WIDTH];
`endif
              end
            end
            default: begin
            end
          endcase
        end

        default: begin
        end
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  // ---------------------------------------------------------------------
  // Status flags, captured only as the write is issued
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else if (state_q == WB) begin
      flag_zero  <= (result_q == '0);
      flag_carry <= carry_q;
    end
  end
`endif

endmodule

// File: tb/tb_reg_alu_sequencer.sv
module tb_reg_alu_sequencer;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [1:0]    instr_op;
  logic [1:0]    instr_dst;
  logic [1:0]    instr_src;
  logic [W-1:0]  instr_imm;
  logic [1:0]    rf_read_index;
  logic [W-1:0]  rf_read_data;
  logic [1:0]    rf_write_index;
  logic          rf_write_enable;
  logic [W-1:0]  rf_write_data;
  logic          busy;
  logic          done;
`ifdef ALU_FLAGS_EN
  logic          flag_zero;
  logic          flag_carry;
`endif

  int errors = 0;
  int checks = 0;

  // Register file that the DUT drives, and the bench's own expectation of it.
  logic [W-1:0] rf     [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [W-1:0] ref_rf [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic         exp_zero  = 1'b0;
  logic         exp_carry = 1'b0;

  always #5 clk = ~clk;

  assign rf_read_data = rf[rf_read_index];

  always @(posedge clk) begin
    if (rf_write_enable) rf[rf_write_index] <= rf_write_data;
  end

  reg_alu_sequencer #(.WIDTH(W), .IDX_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_op        (instr_op),
    .instr_dst       (instr_dst),
    .instr_src       (instr_src),
    .instr_imm       (instr_imm),
    .rf_read_index   (rf_read_index),
    .rf_read_data    (rf_read_data),
    .rf_write_index  (rf_write_index),
    .rf_write_enable (rf_write_enable),
    .rf_write_data   (rf_write_data),
    .busy            (busy),
    .done            (done)
`ifdef ALU_FLAGS_EN
    ,
    .flag_zero       (flag_zero),
    .flag_carry      (flag_carry)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: {carry, result} straight from the arithmetic definition.
  function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [W-1:0] imm);
    longint la, lb, p;
    logic [W:0] r;
    la = longint'(a);
    lb = longint'(b);
    case (op)
      2'd0: r = {1'b0, imm};
      2'd1: begin p = la + lb;         r = {p >= 65536, p[15:0]}; end
      2'd2: begin p = la - lb + 65536; r = {la < lb,   p[15:0]}; end
      default: begin p = la * lb;      r = {p >= 65536, p[15:0]}; end
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [1:0] op);
    if (op == 2'd0) return 1;
    if (op == 2'd3) return 3 + W;
    return 4;
  endfunction

  task automatic scramble_inputs();
    instr_valid = 1'($urandom_range(0, 1));
    instr_op    = 2'($urandom);
    instr_dst   = 2'($urandom);
    instr_src   = 2'($urandom);
    instr_imm   = 16'($urandom);
  endtask

  // Present an instruction and wait for the accept edge; returns one cycle
  // after that edge.
  task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                       input logic [W-1:0] imm, output bit ok);
    ok          = 1'b0;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_dst   = dst;
    instr_src   = src;
    instr_imm   = imm;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (instr_ready) ok = 1'b1;
      step();
    end
    check_val("accept", 32'(ok), 32'd1);
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                           input logic [W-1:0] imm);
    logic [W:0] m;
    bit ok, seen, leak;
    int lat;
    m = model(op, ref_rf[dst], ref_rf[src], imm);
    issue(op, dst, src, imm, ok);
    if (!ok) begin
      instr_valid = 1'b0;
      return;
    end
    lat  = 1;
    seen = 1'b0;
    leak = 1'b0;
    while (!seen && lat <= 40) begin
      if (rf_write_enable) begin
        seen = 1'b1;
      end else begin
        if (instr_ready || done || !busy) leak = 1'b1;
        scramble_inputs();
        step();
        lat++;
      end
    end
    instr_valid = 1'b0;
    check_val("wb_seen", 32'(seen), 32'd1);
    check_val("busy_window", 32'(leak), 32'd0);
    if (!seen) return;
    check_val("latency", 32'(lat), 32'(latency(op)));
    check_val("wr_index", 32'(rf_write_index), 32'(dst));
    check_val("wr_data", 32'(rf_write_data), 32'(m[W-1:0]));
    check_val("done_wb", 32'(done), 32'd1);
    check_val("ready_wb", 32'(instr_ready), 32'd0);
    step();
    ref_rf[dst] = m[W-1:0];
    exp_zero    = (m[W-1:0] == '0);
    exp_carry   = m[W];
    check_val("rf_after_wb", 32'(rf[dst]), 32'(ref_rf[dst]));
    check_val("ready_after_wb", 32'(instr_ready), 32'd1);
    check_val("we_after_wb", 32'(rf_write_enable), 32'd0);
    check_val("done_after_wb", 32'(done), 32'd0);
`ifdef ALU_FLAGS_EN
    check_val("flag_zero", 32'(flag_zero), 32'(exp_zero));
    check_val("flag_carry", 32'(flag_carry), 32'(exp_carry));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, stray;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 2'd0;
    instr_dst   = 2'd0;
    instr_src   = 2'd0;
    instr_imm   = '0;

    // Reset held for two cycles.
    step();
    step();
    check_val("ready_in_reset", 32'(instr_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_we", 32'(rf_write_enable), 32'd0);
    check_val("rst_ready", 32'(instr_ready), 32'd1);
    check_val("rst_rd_idx", 32'(rf_read_index), 32'd0);
    check_val("rst_wr_idx", 32'(rf_write_index), 32'd0);
    check_val("rst_wr_data", 32'(rf_write_data), 32'd0);
`ifdef ALU_FLAGS_EN
    check_val("rst_flag_zero", 32'(flag_zero), 32'd0);
    check_val("rst_flag_carry", 32'(flag_carry), 32'd0);
`endif
    step();

    // Directed cases.
    run_instr(2'd0, 2'd2, 2'd0, 16'h1234);
    check_val("ldi_r2", 32'(rf[2]), 32'h1234);
    run_instr(2'd0, 2'd1, 2'd0, 16'hFFFF);
    run_instr(2'd0, 2'd3, 2'd0, 16'h0002);
    run_instr(2'd1, 2'd1, 2'd3, 16'h0000);
    check_val("add_wrap", 32'(rf[1]), 32'h0001);
`ifdef ALU_FLAGS_EN
    check_val("add_carry", 32'(flag_carry), 32'd1);
`endif
    run_instr(2'd0, 2'd0, 2'd0, 16'h0005);
    run_instr(2'd2, 2'd0, 2'd0, 16'h0000);
    check_val("sub_self", 32'(rf[0]), 32'h0000);
`ifdef ALU_FLAGS_EN
    check_val("sub_zero", 32'(flag_zero), 32'd1);
`endif
    run_instr(2'd0, 2'd2, 2'd0, 16'd300);
    run_instr(2'd0, 2'd1, 2'd0, 16'd7);
    run_instr(2'd3, 2'd2, 2'd1, 16'h0000);
    check_val("mul_300x7", 32'(rf[2]), 32'd2100);

    // Reset during the fifth MUL execute cycle aborts without a write.
    issue(2'd3, 2'd2, 2'd1, 16'h0000, ok);
    instr_valid = 1'b0;
    stray = 1'b0;
    for (int i = 1; i < 7; i++) begin
      if (rf_write_enable) stray = 1'b1;
      step();
    end
    check_val("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check_val("abort_ready_in_reset", 32'(instr_ready), 32'd0);
    check_val("abort_we_in_reset", 32'(rf_write_enable), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check_val("abort_ready", 32'(instr_ready), 32'd1);
    check_val("abort_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 25; i++) begin
      if (rf_write_enable) stray = 1'b1;
      step();
    end
    check_val("abort_no_write", 32'(stray), 32'd0);
    check_val("abort_r2_kept", 32'(rf[2]), 32'(ref_rf[2]));
    exp_zero  = 1'b0;
    exp_carry = 1'b0;
`ifdef ALU_FLAGS_EN
    check_val("abort_flag_zero", 32'(flag_zero), 32'(exp_zero));
    check_val("abort_flag_carry", 32'(flag_carry), 32'(exp_carry));
`endif

    // Randomized instructions with idle gaps and noise on the inputs.
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        instr_valid = 1'b0;
        instr_op    = 2'($urandom);
        instr_imm   = 16'($urandom);
        step();
      end
      run_instr(2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom));
    end

    for (int i = 0; i < 4; i++) begin
      check_val("final_rf", 32'(rf[i]), 32'(ref_rf[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
